// File: rtl/down_counter_timer_pkg.sv
// Shared types and constants for the loadable down-counting timer.
package timer_pkg;

    localparam int DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ARMED  = 2'b01,
        RUN    = 2'b10,
        PAUSED = 2'b11
    } timer_state_t;

endpackage : timer_pkg

// File: rtl/down_counter_timer_if.sv
// Valid/ready load channel carrying the timer start/reload value.
interface down_counter_timer_if
    import timer_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);

    logic             load_valid;
    logic [WIDTH-1:0] load_value;
    logic             load_ready;

    modport master (
        output load_valid,
        output load_value,
        input  load_ready
    );

    modport slave (
        input  load_valid,
        input  load_value,
        output load_ready
    );

endinterface : down_counter_timer_if

// File: rtl/down_counter_timer.sv
// Loadable down-counting timer with start/stop control, one-cycle done pulse
// at terminal count and optional auto-reload for periodic ticks.
module down_counter_timer
    import timer_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    down_counter_timer_if.slave   load,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  auto_reload,
    output logic [WIDTH-1:0]      count,
    output logic                  busy,
    output logic                  done
);

    localparam logic [WIDTH-1:0] ZERO = '0;
    localparam logic [WIDTH-1:0] ONE  = WIDTH'(1'b1);

    timer_state_t     state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic             done_q, done_d;
    logic             load_fire_s;
    logic             load_nonzero_s;

    assign load.load_ready = (state_q == IDLE) || (state_q == ARMED);
    assign load_fire_s     = load.load_valid && load.load_ready;
    assign load_nonzero_s  = load.load_value != ZERO;

    // State, counter, reload and done registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            count_q  <= ZERO;
            reload_q <= ZERO;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            reload_q <= reload_d;
            done_q   <= done_d;
        end
    end

    // Next-state and datapath decisions; done defaults low so it is a single-cycle pulse.
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        reload_d = reload_q;
        done_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (load_fire_s && load_nonzero_s) begin
                    count_d  = load.load_value;
                    reload_d = load.load_value;
                    state_d  = ARMED;
                end else begin
                    state_d  = IDLE;
                end
            end

            ARMED: begin
                // Any accepted load, even a discarded zero, takes priority over start.
                if (load_fire_s) begin
                    if (load_nonzero_s) begin
                        count_d  = load.load_value;
                        reload_d = load.load_value;
                    end else begin
                        count_d  = count_q;
                    end
                end else if (start) begin
                    state_d = RUN;
                end else begin
                    state_d = ARMED;
                end
            end

            RUN: begin
                if (stop) begin
                    state_d = PAUSED;
                end else if (count_q > ONE) begin
                    count_d = count_q - ONE;
                end else if (count_q == ONE) begin
                    done_d = 1'b1;
                    if (auto_reload) begin
                        count_d = reload_q;
                    end else begin
                        count_d = ZERO;
                        state_d = IDLE;
                    end
                end else begin
                    count_d = ZERO;
                    state_d = IDLE;
                end
            end

            PAUSED: begin
                if (stop) begin
                    count_d = ZERO;
                    state_d = IDLE;
                end else if (start) begin
                    state_d = RUN;
                end else begin
                    state_d = PAUSED;
                end
            end

            default: begin
                count_d = ZERO;
                state_d = IDLE;
            end
        endcase
    end

    assign count = count_q;
    assign busy  = (state_q == RUN);
    assign done  = done_q;

endmodule : down_counter_timer

// File: tb/tb_down_counter_timer.sv
// Directed self-checking bench for down_counter_timer with hand-computed expectations.
module tb_down_counter_timer;
    import timer_pkg::*;

    localparam int W = 4;

    logic         clk;
    logic         reset;
    logic         start;
    logic         stop;
    logic         auto_reload;
    logic [W-1:0] count;
    logic         busy;
    logic         done;

    int n_checks;
    int n_fail;

    down_counter_timer_if #(.WIDTH(W)) ld_if ();

    down_counter_timer #(.WIDTH(W)) dut (
        .clk         (clk),
        .reset       (reset),
        .load        (ld_if.slave),
        .start       (start),
        .stop        (stop),
        .auto_reload (auto_reload),
        .count       (count),
        .busy        (busy),
        .done        (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle 1 ns after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_state(input string tag, input int c, input bit b, input bit d);
        check_eq({tag, ".count"}, 32'(count), 32'(c));
        check_eq({tag, ".busy"},  32'(busy),  32'(b));
        check_eq({tag, ".done"},  32'(done),  32'(d));
    endtask

    task automatic do_load(input int v);
        ld_if.load_valid = 1'b1;
        ld_if.load_value = W'(v);
        tick();
        ld_if.load_valid = 1'b0;
        ld_if.load_value = '0;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic do_stop();
        stop = 1'b1;
        tick();
        stop = 1'b0;
    endtask

    initial begin
        int seq2 [7] = '{2, 1, 3, 2, 1, 3, 2};
        n_checks = 0;
        n_fail   = 0;
        reset = 1'b0;
        start = 1'b0;
        stop  = 1'b0;
        auto_reload = 1'b0;
        ld_if.load_valid = 1'b0;
        ld_if.load_value = '0;

        #20;
        expect_state("rst", 0, 1'b0, 1'b0);
        check_eq("rst.ready", 32'(ld_if.load_ready), 32'd1);
        @(negedge clk);
        reset = 1'b1;
        tick();

        // 1: one-shot count from 5
        do_load(5);
        expect_state("t1.armed", 5, 1'b0, 1'b0);
        check_eq("t1.armed.ready", 32'(ld_if.load_ready), 32'd1);
        do_start();
        expect_state("t1.run", 5, 1'b1, 1'b0);
        check_eq("t1.run.ready", 32'(ld_if.load_ready), 32'd0);
        for (int i = 4; i >= 1; i--) begin
            tick();
            expect_state("t1.dec", i, 1'b1, 1'b0);
        end
        tick();
        expect_state("t1.tc", 0, 1'b0, 1'b1);
        tick();
        expect_state("t1.after", 0, 1'b0, 1'b0);

        // 2: periodic tick with auto-reload, then drop it
        auto_reload = 1'b1;
        do_load(3);
        do_start();
        expect_state("t2.run", 3, 1'b1, 1'b0);
        for (int i = 0; i < 7; i++) begin
            tick();
            expect_state("t2.per", seq2[i], 1'b1, seq2[i] == 3);
        end
        auto_reload = 1'b0;
        tick();
        expect_state("t2.last1", 1, 1'b1, 1'b0);
        tick();
        expect_state("t2.end", 0, 1'b0, 1'b1);

        // 3: pause holds, resume continues, then stop-stop aborts
        do_load(9);
        do_start();
        tick();
        tick();
        expect_state("t3.pre", 7, 1'b1, 1'b0);
        do_stop();
        expect_state("t3.paused", 7, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            expect_state("t3.hold", 7, 1'b0, 1'b0);
        end
        do_start();
        expect_state("t3.resume", 7, 1'b1, 1'b0);
        tick();
        expect_state("t3.r6", 6, 1'b1, 1'b0);
        tick();
        expect_state("t3.r5", 5, 1'b1, 1'b0);
        do_stop();
        expect_state("t3.p2", 5, 1'b0, 1'b0);
        do_stop();
        expect_state("t3.abort", 0, 1'b0, 1'b0);
        check_eq("t3.abort.ready", 32'(ld_if.load_ready), 32'd1);
        tick();
        check_eq("t3.nodone", 32'(done), 32'd0);

        // 4: load boundaries
        do_load(0);
        expect_state("t4.zero", 0, 1'b0, 1'b0);
        do_start();
        expect_state("t4.zero.start", 0, 1'b0, 1'b0);
        do_load(15);
        expect_state("t4.max", 15, 1'b0, 1'b0);
        do_load(4);
        expect_state("t4.over", 4, 1'b0, 1'b0);
        start = 1'b1;
        do_load(6);
        start = 1'b0;
        expect_state("t4.ldstart", 6, 1'b0, 1'b0);
        check_eq("t4.ldstart.ready", 32'(ld_if.load_ready), 32'd1);
        do_start();
        expect_state("t4.run", 6, 1'b1, 1'b0);
        ld_if.load_valid = 1'b1;
        ld_if.load_value = 4'd2;
        #1;
        check_eq("t4.run.ready", 32'(ld_if.load_ready), 32'd0);
        tick();
        ld_if.load_valid = 1'b0;
        ld_if.load_value = '0;
        expect_state("t4.run.ign", 5, 1'b1, 1'b0);
        do_stop();
        do_stop();
        expect_state("t4.clean", 0, 1'b0, 1'b0);

        // 5: asynchronous reset mid-run
        do_load(12);
        do_start();
        for (int i = 0; i < 4; i++) tick();
        expect_state("t5.pre", 8, 1'b1, 1'b0);
        #2;
        reset = 1'b0;
        #1;
        expect_state("t5.async", 0, 1'b0, 1'b0);
        check_eq("t5.async.ready", 32'(ld_if.load_ready), 32'd1);
        #2;
        reset = 1'b1;
        tick();
        expect_state("t5.release", 0, 1'b0, 1'b0);
        do_start();
        expect_state("t5.start.alone", 0, 1'b0, 1'b0);

        // 6: stop beats start in RUN
        do_load(12);
        do_start();
        tick();
        tick();
        expect_state("t6.pre", 10, 1'b1, 1'b0);
        stop  = 1'b1;
        start = 1'b1;
        tick();
        stop  = 1'b0;
        start = 1'b0;
        expect_state("t6.paused", 10, 1'b0, 1'b0);
        tick();
        expect_state("t6.hold", 10, 1'b0, 1'b0);
        do_stop();
        expect_state("t6.abort", 0, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_down_counter_timer
